// File: rtl/foot_frame_parser_if.sv
// Byte-stream and result bundle for the foot-sensor frame parser.
// The byte receiver drives the stream, the parser drives the results.
interface foot_frame_parser_if #(
  parameter int NUM_CH   = 32,
  parameter int CH_BYTES = 1
);
  localparam int VW = NUM_CH * CH_BYTES * 8;

  logic [7:0]    rxd;
  logic          rxdv;
  logic [31:0]   usecs;
  logic [VW-1:0] values;
  logic          frame_good;
  logic          frame_err;
  logic [1:0]    err_code;
  logic [15:0]   good_cnt;
  logic [15:0]   err_cnt;

  modport master (
    output rxd, rxdv,
    input  usecs, values, frame_good, frame_err, err_code, good_cnt, err_cnt
  );

  modport slave (
    input  rxd, rxdv,
    output usecs, values, frame_good, frame_err, err_code, good_cnt, err_cnt
  );
endinterface

// File: rtl/foot_frame_parser.sv
// Parses one rxdv-framed sensor frame into a timestamp and NUM_CH channel values;
// results commit atomically only for a validated frame, bad frames are counted.
module foot_frame_parser #(
  parameter int HDR_BYTES = 4,
  parameter int NUM_CH    = 32,
  parameter int CH_BYTES  = 1,
  parameter int CSUM_EN   = 1
) (
  input logic                c,
  input logic                rst_n,
  foot_frame_parser_if.slave bus
);

  localparam int NB = NUM_CH * CH_BYTES;
  localparam int VW = NB * 8;
  localparam int L  = HDR_BYTES + 4 + NB + CSUM_EN;
  localparam int NW = $clog2(L + 2);

  localparam logic [NW-1:0] LEN     = NW'(L);
  localparam logic [NW-1:0] N_MAX   = NW'(L + 1);
  localparam logic [NW-1:0] USEC_LO = NW'(HDR_BYTES);
  localparam logic [NW-1:0] CH_LO   = NW'(HDR_BYTES + 4);

  typedef enum logic [1:0] {SYNC, IDLE, RECV, DONE} state_e;
  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_SHORT = 2'd1,
    ERR_LONG  = 2'd2,
    ERR_CSUM  = 2'd3
  } err_code_e;

  state_e          state_q, state_d;
  logic [NW-1:0]   n_q, n_d;
  logic [7:0]      csum_q, csum_d;
  logic [31:0]     sh_usecs_q, sh_usecs_d;
  logic [VW-1:0]   sh_vals_q, sh_vals_d;
  logic [31:0]     usecs_q, usecs_d;
  logic [VW-1:0]   values_q, values_d;
  logic            good_q, good_d;
  logic            err_q, err_d;
  err_code_e       code_q, code_d;
  logic [15:0]     good_cnt_q, good_cnt_d;
  logic [15:0]     err_cnt_q, err_cnt_d;

  logic            take;
  logic            first;
  logic            judge;
  logic            in_csum;
  logic            csum_bad;
  logic [NW-1:0]   idx;

  // State register
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) state_q <= SYNC;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SYNC: if (!bus.rxdv) state_d = IDLE;
      IDLE: if (bus.rxdv)  state_d = RECV;
      RECV: if (!bus.rxdv) state_d = DONE;
      DONE: state_d = bus.rxdv ? RECV : IDLE;
      default: state_d = SYNC;
    endcase
  end

  // A byte arriving in IDLE or DONE always restarts the frame at index 0.
  always_comb begin
    take     = bus.rxdv && (state_q != SYNC);
    first    = bus.rxdv && ((state_q == IDLE) || (state_q == DONE));
    idx      = first ? '0 : n_q;
    in_csum  = (idx >= USEC_LO) && (idx < LEN);
    judge    = (state_q == RECV) && !bus.rxdv;
    csum_bad = (CSUM_EN != 0) && (csum_q != 8'h00);
  end

  // Output / datapath logic
  // NOTE: every always_comb target gets a default first, so no path can infer a latch.
  always_comb begin
    n_d        = n_q;
    csum_d     = csum_q;
    sh_usecs_d = sh_usecs_q;
    sh_vals_d  = sh_vals_q;
    usecs_d    = usecs_q;
    values_d   = values_q;
    good_d     = 1'b0;
    err_d      = 1'b0;
    code_d     = code_q;
    good_cnt_d = good_cnt_q;
    err_cnt_d  = err_cnt_q;

    if (take) begin
      n_d    = (idx == N_MAX) ? idx : idx + 1'b1;
      csum_d = (first ? 8'h00 : csum_q) ^ (in_csum ? bus.rxd : 8'h00);
      for (int b = 0; b < 4; b++) begin
        if (idx == USEC_LO + NW'(b)) sh_usecs_d[b*8 +: 8] = bus.rxd;
      end
      for (int j = 0; j < NB; j++) begin
        if (idx == CH_LO + NW'(j)) sh_vals_d[j*8 +: 8] = bus.rxd;
      end
    end

    // Judgement sits on the RECV->DONE edge so the pulse is visible while in DONE.
    if (judge) begin
      if ((n_q != LEN) || csum_bad) begin
        err_d     = 1'b1;
        code_d    = (n_q < LEN) ? ERR_SHORT : (n_q > LEN) ? ERR_LONG : ERR_CSUM;
        err_cnt_d = (err_cnt_q == 16'hFFFF) ? err_cnt_q : err_cnt_q + 16'd1;
      end else begin
        good_d     = 1'b1;
        usecs_d    = sh_usecs_q;
        values_d   = sh_vals_q;
        good_cnt_d = (good_cnt_q == 16'hFFFF) ? good_cnt_q : good_cnt_q + 16'd1;
      end
    end
  end

  // NOTE: the shadow buffer is reset with everything else; it is plain flops, not a RAM,
  // so clearing it is free and keeps the design X-free.
  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      n_q        <= '0;
      csum_q     <= '0;
      sh_usecs_q <= '0;
      sh_vals_q  <= '0;
      usecs_q    <= '0;
      values_q   <= '0;
      good_q     <= 1'b0;
      err_q      <= 1'b0;
      code_q     <= ERR_NONE;
      good_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      n_q        <= n_d;
      csum_q     <= csum_d;
      sh_usecs_q <= sh_usecs_d;
      sh_vals_q  <= sh_vals_d;
      usecs_q    <= usecs_d;
      values_q   <= values_d;
      good_q     <= good_d;
      err_q      <= err_d;
      code_q     <= code_d;
      good_cnt_q <= good_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign bus.usecs      = usecs_q;
  assign bus.values     = values_q;
  assign bus.frame_good = good_q;
  assign bus.frame_err  = err_q;
  assign bus.err_code   = code_q;
  assign bus.good_cnt   = good_cnt_q;
  assign bus.err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_foot_frame_parser.sv
// Directed bench for foot_frame_parser: default 32x8-bit parser (dut_a) and a
// 4x16-bit no-checksum variant (dut_b) share clock, reset and byte driver.
module tb_foot_frame_parser;

  logic       c = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rxd_drv = 8'h00;
  logic       rxdv_drv = 1'b0;
  logic       sel = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]   frm [0:63];
  logic [255:0] exp_vals_a;

  always #5 c = ~c;

  foot_frame_parser_if #(.NUM_CH(32), .CH_BYTES(1)) if_a ();
  foot_frame_parser_if #(.NUM_CH(4),  .CH_BYTES(2)) if_b ();

  assign if_a.rxd  = rxd_drv;
  assign if_a.rxdv = rxdv_drv & ~sel;
  assign if_b.rxd  = rxd_drv;
  assign if_b.rxdv = rxdv_drv & sel;

  foot_frame_parser #(.HDR_BYTES(4), .NUM_CH(32), .CH_BYTES(1), .CSUM_EN(1)) dut_a (
    .c(c), .rst_n(rst_n), .bus(if_a)
  );

  foot_frame_parser #(.HDR_BYTES(4), .NUM_CH(4), .CH_BYTES(2), .CSUM_EN(0)) dut_b (
    .c(c), .rst_n(rst_n), .bus(if_b)
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // 41-byte default frame: AA header, LE usecs, ch k = base+k, XOR checksum ^ flip.
  task automatic build_a(input logic [31:0] us, input logic [7:0] base, input logic [7:0] flip);
    logic [7:0] cs;
    for (int i = 0; i < 4; i++) frm[i] = 8'hAA;
    for (int i = 0; i < 4; i++) frm[4+i] = us[i*8 +: 8];
    for (int k = 0; k < 32; k++) frm[8+k] = base + 8'(k);
    cs = 8'h00;
    for (int i = 4; i < 40; i++) cs = cs ^ frm[i];
    frm[40] = cs ^ flip;
    for (int i = 41; i < 64; i++) frm[i] = 8'h00;
  endtask

  // Caller is at a negedge; returns at the negedge where the result pulse is visible.
  task automatic send(input int len);
    for (int i = 0; i < len; i++) begin
      rxd_drv  = frm[i];
      rxdv_drv = 1'b1;
      @(negedge c);
    end
    rxdv_drv = 1'b0;
    rxd_drv  = 8'h00;
    @(negedge c);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 32; k++) exp_vals_a[k*8 +: 8] = 8'(k);

    repeat (3) @(negedge c);
    rst_n = 1'b1;
    @(negedge c);

    check("rst_usecs",    32'(if_a.usecs), 32'h0);
    check("rst_values",   if_a.values, 256'h0);
    check("rst_good_cnt", 16'(if_a.good_cnt), 16'h0);
    check("rst_err_cnt",  16'(if_a.err_cnt), 16'h0);
    check("rst_err_code", 2'(if_a.err_code), 2'd0);

    // Valid frame
    build_a(32'h12345678, 8'h00, 8'h00);
    send(41);
    check("a1_good",     1'(if_a.frame_good), 1'b1);
    check("a1_err",      1'(if_a.frame_err), 1'b0);
    check("a1_usecs",    32'(if_a.usecs), 32'h12345678);
    check("a1_values",   if_a.values, exp_vals_a);
    check("a1_good_cnt", 16'(if_a.good_cnt), 16'd1);
    @(negedge c);
    check("a1_pulse_end", 1'(if_a.frame_good), 1'b0);

    // Bad checksum, different payload must not leak out
    build_a(32'hCAFEF00D, 8'h40, 8'h01);
    send(41);
    check("a2_err",      1'(if_a.frame_err), 1'b1);
    check("a2_good",     1'(if_a.frame_good), 1'b0);
    check("a2_code",     2'(if_a.err_code), 2'd3);
    check("a2_usecs",    32'(if_a.usecs), 32'h12345678);
    check("a2_values",   if_a.values, exp_vals_a);
    check("a2_err_cnt",  16'(if_a.err_cnt), 16'd1);

    // Short frame (40 bytes)
    build_a(32'h0BADF00D, 8'h80, 8'h00);
    send(40);
    check("a3_err",      1'(if_a.frame_err), 1'b1);
    check("a3_code",     2'(if_a.err_code), 2'd1);
    check("a3_usecs",    32'(if_a.usecs), 32'h12345678);
    check("a3_err_cnt",  16'(if_a.err_cnt), 16'd2);
    check("a3_good_cnt", 16'(if_a.good_cnt), 16'd1);

    // Long frame (45 bytes, checksum itself valid)
    build_a(32'h0BADF00D, 8'h80, 8'h00);
    send(45);
    check("a4_err",      1'(if_a.frame_err), 1'b1);
    check("a4_code",     2'(if_a.err_code), 2'd2);
    check("a4_values",   if_a.values, exp_vals_a);
    check("a4_err_cnt",  16'(if_a.err_cnt), 16'd3);
    @(negedge c);
    check("a4_code_held", 2'(if_a.err_code), 2'd2);

    // Variant: 4 x 16-bit LE channels, no checksum, back-to-back with one idle cycle
    sel = 1'b1;
    for (int i = 0; i < 4; i++) frm[i] = 8'h55;
    frm[4] = 8'h01; frm[5] = 8'h00; frm[6] = 8'h00; frm[7] = 8'h00;
    frm[8]  = 8'h34; frm[9]  = 8'h12; frm[10] = 8'h78; frm[11] = 8'h56;
    frm[12] = 8'hBC; frm[13] = 8'h9A; frm[14] = 8'hF0; frm[15] = 8'hDE;
    send(16);
    check("b1_good",   1'(if_b.frame_good), 1'b1);
    check("b1_usecs",  32'(if_b.usecs), 32'h00000001);
    check("b1_values", 64'(if_b.values), 64'hDEF0_9ABC_5678_1234);
    frm[4] = 8'h02;
    frm[8]  = 8'h11; frm[9]  = 8'h22; frm[10] = 8'h33; frm[11] = 8'h44;
    frm[12] = 8'h55; frm[13] = 8'h66; frm[14] = 8'h77; frm[15] = 8'h88;
    send(16);
    check("b2_good",     1'(if_b.frame_good), 1'b1);
    check("b2_usecs",    32'(if_b.usecs), 32'h00000002);
    check("b2_values",   64'(if_b.values), 64'h8877_6655_4433_2211);
    check("b2_good_cnt", 16'(if_b.good_cnt), 16'd2);
    check("b2_err_cnt",  16'(if_b.err_cnt), 16'd0);
    check("b2_a_quiet",  16'(if_a.good_cnt), 16'd1);
    sel = 1'b0;

    // Reset asserted mid-frame and released while rxdv is still high
    build_a(32'hA5A50001, 8'h10, 8'h00);
    for (int i = 0; i < 41; i++) begin
      if (i == 10) rst_n = 1'b0;
      if (i == 15) rst_n = 1'b1;
      rxd_drv  = frm[i];
      rxdv_drv = 1'b1;
      @(negedge c);
    end
    rxdv_drv = 1'b0;
    rxd_drv  = 8'h00;
    @(negedge c);
    check("r_good",     1'(if_a.frame_good), 1'b0);
    check("r_err",      1'(if_a.frame_err), 1'b0);
    check("r_good_cnt", 16'(if_a.good_cnt), 16'd0);
    check("r_err_cnt",  16'(if_a.err_cnt), 16'd0);
    check("r_usecs",    32'(if_a.usecs), 32'h0);
    build_a(32'h12345678, 8'h00, 8'h00);
    send(41);
    check("r2_good",     1'(if_a.frame_good), 1'b1);
    check("r2_good_cnt", 16'(if_a.good_cnt), 16'd1);
    check("r2_usecs",    32'(if_a.usecs), 32'h12345678);

    // Good-frame counter saturation
    force dut_a.good_cnt_q = 16'hFFFF;
    @(negedge c);
    release dut_a.good_cnt_q;
    check("s_preload", 16'(if_a.good_cnt), 16'hFFFF);
    build_a(32'h0F0F0F0F, 8'h20, 8'h00);
    send(41);
    check("s_good",     1'(if_a.frame_good), 1'b1);
    check("s_good_cnt", 16'(if_a.good_cnt), 16'hFFFF);
    check("s_usecs",    32'(if_a.usecs), 32'h0F0F0F0F);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
